// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: ID-stage stall/flush sequencing for hazards forwarding cannot cover.
// Define HAZARD_STATS_EN to build the Stall_Cycles/Flush_Count counters.
module hazard_stall_ctrl #(
  parameter int ADDR_W = 5,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Rs_ID,
  input  logic [ADDR_W-1:0] Rt_ID,
  input  logic              UseRs_ID,
  input  logic              UseRt_ID,
  input  logic              Branch_ID,
  input  logic              Jump_ID,
  input  logic              BranchTaken_ID,
  input  logic [ADDR_W-1:0] Address_ID_EX,
  input  logic              RegWrite_ID_EX,
  input  logic              MemRead_ID_EX,
  input  logic [ADDR_W-1:0] Address_EX_MEM,
  input  logic              MemRead_EX_MEM,
  input  logic              MemBusy,
  output logic              PC_Write,
  output logic              IF_ID_Write,
  output logic              ID_EX_Bubble,
  output logic              IF_ID_Flush,
  output logic [STAT_W-1:0] Stall_Cycles,
  output logic [STAT_W-1:0] Flush_Count
);
  typedef enum logic {IDLE, STALL} state_t;
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d, need;
  logic ex_hit, mem_hit, ex_load, ex_wr, mem_load, stall, flush;
  assign ex_hit  = Address_ID_EX != '0 &&
                   ((UseRs_ID && Address_ID_EX == Rs_ID) || (UseRt_ID && Address_ID_EX == Rt_ID));
  assign mem_hit = Address_EX_MEM != '0 &&
                   ((UseRs_ID && Address_EX_MEM == Rs_ID) || (UseRt_ID && Address_EX_MEM == Rt_ID));
  assign ex_load  = ex_hit && MemRead_ID_EX;
  assign ex_wr    = ex_hit && RegWrite_ID_EX && !MemRead_ID_EX;
  assign mem_load = mem_hit && MemRead_EX_MEM;
  // Branches compare in ID, so they also wait on ALU results and MEM-stage loads.
  assign need = Branch_ID ? (ex_load ? 2'd2 : (ex_wr || mem_load) ? 2'd1 : 2'd0)
                          : (ex_load ? 2'd1 : 2'd0);
  assign stall = !MemBusy && (state_q == STALL || need != 2'd0);
  assign flush = !MemBusy && state_q == IDLE && need == 2'd0 &&
                 (Jump_ID || (Branch_ID && BranchTaken_ID));
  assign PC_Write     = !MemBusy && !stall;
  assign IF_ID_Write  = !MemBusy && !stall;
  assign ID_EX_Bubble = stall;
  assign IF_ID_Flush  = flush;
  always_comb begin
    cnt_d   = MemBusy ? cnt_q : state_q == STALL ? cnt_q - 2'd1 : need != 2'd0 ? need - 2'd1 : cnt_q;
    state_d = MemBusy ? state_q : state_q == STALL ? (cnt_q == 2'd1 ? IDLE : STALL)
                                                   : (need > 2'd1 ? STALL : IDLE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q, flush_cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + STAT_W'(stall);
      flush_cnt_q <= flush_cnt_q + STAT_W'(flush);
    end
  end
  assign Stall_Cycles = stall_cnt_q;
  assign Flush_Count  = flush_cnt_q;
`else
  assign Stall_Cycles = '0;
  assign Flush_Count  = '0;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed + random stimulus against a cycle-level reference model.
module tb_hazard_stall_ctrl;
  localparam int AW = 5;
  localparam int SW = 32;
  logic clk = 1'b0, reset;
  logic [AW-1:0] rs, rt, a_ex, a_mem;
  logic urs, urt, br, jmp, taken, rw_ex, mr_ex, mr_mem, busy;
  logic pcw, ifw, bub, fl;
  logic [SW-1:0] st_cyc, fl_cnt;
  int total = 0, bad = 0;
  int rem = 0, sc = 0, fc = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.ADDR_W(AW), .STAT_W(SW)) dut (
    .clk(clk), .reset(reset), .Rs_ID(rs), .Rt_ID(rt), .UseRs_ID(urs), .UseRt_ID(urt),
    .Branch_ID(br), .Jump_ID(jmp), .BranchTaken_ID(taken), .Address_ID_EX(a_ex),
    .RegWrite_ID_EX(rw_ex), .MemRead_ID_EX(mr_ex), .Address_EX_MEM(a_mem),
    .MemRead_EX_MEM(mr_mem), .MemBusy(busy), .PC_Write(pcw), .IF_ID_Write(ifw),
    .ID_EX_Bubble(bub), .IF_ID_Flush(fl), .Stall_Cycles(st_cyc), .Flush_Count(fl_cnt)
  );

  function automatic bit reads(input logic [AW-1:0] a);
    return a != 0 && ((urs && a == rs) || (urt && a == rt));
  endfunction

  function automatic int need_m();
    if (br) begin
      if (reads(a_ex) && mr_ex) return 2;
      if ((reads(a_ex) && rw_ex) || (reads(a_mem) && mr_mem)) return 1;
      return 0;
    end
    return (reads(a_ex) && mr_ex) ? 1 : 0;
  endfunction

  task automatic clr();
    reset = 0; rs = 0; rt = 0; a_ex = 0; a_mem = 0; urs = 0; urt = 0; br = 0; jmp = 0;
    taken = 0; rw_ex = 0; mr_ex = 0; mr_mem = 0; busy = 0;
  endtask

  task automatic cyc(input string tag);
    logic [3:0] exp_o, got_o;
    int n;
    bit is_fl, is_st;
    n = need_m();
    is_st = !busy && (rem > 0 || n > 0);
    is_fl = !busy && rem == 0 && n == 0 && (jmp || (br && taken));
    exp_o = busy ? 4'b0000 : is_st ? 4'b0010 : is_fl ? 4'b1101 : 4'b1100;
    @(negedge clk);
    got_o = {pcw, ifw, bub, fl};
    total++;
    assert (got_o === exp_o) else begin
      bad++;
      $error("FAIL %s ctrl {pc,ifid,bub,flush} got=%b exp=%b", tag, got_o, exp_o);
    end
    total++;
    assert (st_cyc === SW'(sc)) else begin
      bad++;
      $error("FAIL %s Stall_Cycles got=%0d exp=%0d", tag, st_cyc, sc);
    end
    total++;
    assert (fl_cnt === SW'(fc)) else begin
      bad++;
      $error("FAIL %s Flush_Count got=%0d exp=%0d", tag, fl_cnt, fc);
    end
    @(posedge clk);
    if (reset) begin
      rem = 0; sc = 0; fc = 0;
    end else if (!busy) begin
`ifdef HAZARD_STATS_EN
      if (is_st) sc++;
      if (is_fl) fc++;
`endif
      if (rem > 0) rem--;
      else if (n > 0) rem = n - 1;
    end
    #1;
  endtask

  initial begin
    clr();
    reset = 1;
    @(posedge clk); #1;
    cyc("reset");
    reset = 0;
    cyc("idle");
    mr_ex = 1; rw_ex = 1; a_ex = 5; rs = 5; urs = 1;
    cyc("loaduse_stall");
    clr();
    cyc("loaduse_after");
    br = 1; mr_ex = 1; rw_ex = 1; a_ex = 8; rt = 8; urt = 1;
    cyc("ldbr_stall1");
    cyc("ldbr_stall2");
    clr(); br = 1; taken = 1;
    cyc("ldbr_flush");
    clr();
    cyc("ldbr_after");
    mr_ex = 1; a_ex = 0; rs = 0; urs = 1;
    cyc("reg0_nostall");
    clr(); jmp = 1;
    cyc("jump_flush");
    clr();
    cyc("jump_after");
    br = 1; rw_ex = 1; a_ex = 3; rs = 3; urs = 1; taken = 1;
    cyc("alu_br_stall");
    clr(); br = 1; a_mem = 4; mr_mem = 1; rt = 4; urt = 1;
    cyc("memld_br_stall");
    clr();
    br = 1; mr_ex = 1; a_ex = 8; rt = 8; urt = 1;
    cyc("busy_stall1");
    busy = 1;
    for (int i = 0; i < 3; i++) cyc("busy_freeze");
    busy = 0;
    cyc("busy_resume");
    clr();
    cyc("busy_after");
    br = 1; mr_ex = 1; a_ex = 8; rt = 8; urt = 1;
    cyc("rst_stall1");
    clr(); reset = 1;
    cyc("rst_mid");
    reset = 0;
    cyc("rst_after");
    for (int i = 0; i < 400; i++) begin
      rs = AW'($urandom_range(0, 3)); rt = AW'($urandom_range(0, 3));
      a_ex = AW'($urandom_range(0, 3)); a_mem = AW'($urandom_range(0, 3));
      urs = 1'($urandom); urt = 1'($urandom); br = 1'($urandom);
      jmp = !br && ($urandom_range(0, 3) == 0); taken = 1'($urandom);
      rw_ex = 1'($urandom); mr_ex = 1'($urandom); mr_mem = 1'($urandom);
      busy = $urandom_range(0, 6) == 0; reset = $urandom_range(0, 40) == 0;
      cyc("random");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
